// File: rtl/bip_ctrl_seq_pkg.sv
// Shared opcode map, datapath select encodings and sequencer states for the BIP controller.
package bip_ctrl_seq_pkg;

    localparam int unsigned OPC_HLT  = 0;
    localparam int unsigned OPC_STO  = 1;
    localparam int unsigned OPC_LD   = 2;
    localparam int unsigned OPC_LDI  = 3;
    localparam int unsigned OPC_ADD  = 4;
    localparam int unsigned OPC_ADDI = 5;
    localparam int unsigned OPC_SUB  = 6;
    localparam int unsigned OPC_SUBI = 7;
    localparam int unsigned OPC_BEQ  = 8;
    localparam int unsigned OPC_BNE  = 9;
    localparam int unsigned OPC_JMP  = 10;

    localparam logic [1:0] SEL_A_RAM     = 2'b00;
    localparam logic [1:0] SEL_A_OPERAND = 2'b01;
    localparam logic [1:0] SEL_A_ALU     = 2'b10;

    localparam logic SEL_B_RAM     = 1'b0;
    localparam logic SEL_B_OPERAND = 1'b1;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StHalt = 1'b1
    } state_t;

endpackage

// File: rtl/bip_ctrl_seq_decoder.sv
// Combinational opcode decoder; all outputs are zero unless 'active'.
// Branch decode exists only when BIP_BRANCH_EN is defined.
module bip_ctrl_seq_decoder
    import bip_ctrl_seq_pkg::*;
#(
    parameter int unsigned OPCODE_W = 5
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                active,
    input  logic                acc_zero,
    output logic [1:0]          sel_a,
    output logic                sel_b,
    output logic                op,
    output logic                wr_acc,
    output logic                wr_ram,
    output logic                rd_ram,
    output logic                is_branch,
    output logic                is_halt
);

`ifndef BIP_BRANCH_EN
    logic unused_acc_zero;
    assign unused_acc_zero = acc_zero;
`endif

    always_comb begin
        sel_a     = SEL_A_RAM;
        sel_b     = SEL_B_RAM;
        op        = OP_ADD;
        wr_acc    = 1'b0;
        wr_ram    = 1'b0;
        rd_ram    = 1'b0;
        is_branch = 1'b0;
        is_halt   = 1'b0;
        if (active) begin
            case (opcode)
                OPCODE_W'(OPC_HLT): is_halt = 1'b1;
                OPCODE_W'(OPC_STO): wr_ram = 1'b1;
                OPCODE_W'(OPC_LD): begin
                    rd_ram = 1'b1;
                    wr_acc = 1'b1;
                    sel_a  = SEL_A_RAM;
                end
                OPCODE_W'(OPC_LDI): begin
                    wr_acc = 1'b1;
                    sel_a  = SEL_A_OPERAND;
                end
                OPCODE_W'(OPC_ADD), OPCODE_W'(OPC_SUB): begin
                    rd_ram = 1'b1;
                    wr_acc = 1'b1;
                    sel_a  = SEL_A_ALU;
                    sel_b  = SEL_B_RAM;
                    op     = (opcode == OPCODE_W'(OPC_SUB)) ? OP_SUB : OP_ADD;
                end
                OPCODE_W'(OPC_ADDI), OPCODE_W'(OPC_SUBI): begin
                    wr_acc = 1'b1;
                    sel_a  = SEL_A_ALU;
                    sel_b  = SEL_B_OPERAND;
                    op     = (opcode == OPCODE_W'(OPC_SUBI)) ? OP_SUB : OP_ADD;
                end
`ifdef BIP_BRANCH_EN
                OPCODE_W'(OPC_BEQ): is_branch = acc_zero;
                OPCODE_W'(OPC_BNE): is_branch = !acc_zero;
                OPCODE_W'(OPC_JMP): is_branch = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bip_ctrl_seq.sv
// BIP control sequencer: PC, instruction register, RUN/HALT state and saturating cycle counter.
// Conditional/unconditional branches with fetch flush are built only when BIP_BRANCH_EN is defined.
module bip_ctrl_seq
    import bip_ctrl_seq_pkg::*;
#(
    parameter int unsigned OPCODE_W     = 5,
    parameter int unsigned OPERAND_W    = 11,
    parameter int unsigned PC_W         = 11,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [OPCODE_W+OPERAND_W-1:0] instruction,
    input  logic                          acc_zero,
    output logic [PC_W-1:0]               pc,
    output logic [OPERAND_W-1:0]          operand,
    output logic [1:0]                    sel_a,
    output logic                          sel_b,
    output logic                          op,
    output logic                          wr_acc,
    output logic                          wr_ram,
    output logic                          rd_ram,
    output logic                          halted,
    output logic [CNT_W-1:0]              cycle_count
);

    localparam int unsigned INSTR_W = OPCODE_W + OPERAND_W;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 ir_valid_q, ir_valid_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 running;
    logic                 active;
    logic                 is_branch;
    logic                 is_halt;

    assign running = enable && (state_q == StRun);
    assign active  = running && ir_valid_q;

    bip_ctrl_seq_decoder #(
        .OPCODE_W (OPCODE_W)
    ) u_decoder (
        .opcode    (ir_q[INSTR_W-1 -: OPCODE_W]),
        .active    (active),
        .acc_zero  (acc_zero),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .op        (op),
        .wr_acc    (wr_acc),
        .wr_ram    (wr_ram),
        .rd_ram    (rd_ram),
        .is_branch (is_branch),
        .is_halt   (is_halt)
    );

`ifdef BIP_BRANCH_EN
    // Target is the low operand bits, zero-extended when the PC is wider.
    localparam int unsigned TGT_W = (PC_W < OPERAND_W) ? PC_W : OPERAND_W;
    logic [PC_W-1:0] branch_target;

    always_comb begin
        branch_target            = '0;
        branch_target[TGT_W-1:0] = ir_q[TGT_W-1:0];
    end
`else
    logic unused_is_branch;
    assign unused_is_branch = is_branch;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        cnt_d      = cnt_q;
        if (running) begin
            if (is_halt) begin
                // The halting edge freezes pc, IR and the counter.
                state_d = StHalt;
            end else begin
                ir_d       = instruction;
                ir_valid_d = 1'b1;
                pc_d       = pc_q + PC_W'(1);
                cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef BIP_BRANCH_EN
                if (is_branch) begin
                    // Word fetched this edge is wrong-path; drop it as a bubble.
                    pc_d       = branch_target;
                    ir_valid_d = 1'b0;
                end
`endif
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StRun;
            pc_q       <= PC_W'(RESET_VECTOR);
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign operand     = ir_q[OPERAND_W-1:0];
    assign halted      = (state_q == StHalt);
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_bip_ctrl_seq.sv
// Self-checking bench for bip_ctrl_seq: directed program scenarios plus randomized programs
// compared against an instruction-level reference model.
module tb_bip_ctrl_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        acc_zero = 1'b0;
    logic [15:0] instruction;
    logic [10:0] pc;
    logic [10:0] operand;
    logic [1:0]  sel_a;
    logic        sel_b, op, wr_acc, wr_ram, rd_ram, halted;
    logic [31:0] cycle_count;
    logic [6:0]  strobes;

    logic [15:0] mem [0:2047];

    int checks = 0;
    int failures = 0;

`ifdef BIP_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    // Reference model state
    int unsigned     m_pc;
    logic [15:0]     m_ir;
    bit              m_valid;
    bit              m_halt;
    longint unsigned m_cnt;

    always #5 clock = ~clock;

    assign instruction = mem[pc];
    assign strobes = {sel_a, sel_b, op, wr_acc, wr_ram, rd_ram};

    bip_ctrl_seq dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .instruction (instruction),
        .acc_zero    (acc_zero),
        .pc          (pc),
        .operand     (operand),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .op          (op),
        .wr_acc      (wr_acc),
        .wr_ram      (wr_ram),
        .rd_ram      (rd_ram),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    function automatic logic [15:0] ins(input int o, input int d);
        return {o[4:0], d[10:0]};
    endfunction

    // {sel_a, sel_b, op, wr_acc, wr_ram, rd_ram} for an executing opcode
    function automatic logic [6:0] exp_dec(input logic [4:0] o);
        case (o)
            5'd1:    return 7'b00_0_0_010;
            5'd2:    return 7'b00_0_0_101;
            5'd3:    return 7'b01_0_0_100;
            5'd4:    return 7'b10_0_0_101;
            5'd5:    return 7'b10_1_0_100;
            5'd6:    return 7'b10_0_1_101;
            5'd7:    return 7'b10_1_1_100;
            default: return 7'b0;
        endcase
    endfunction

    function automatic void model_reset();
        m_pc = 0; m_ir = '0; m_valid = 0; m_halt = 0; m_cnt = 0;
    endfunction

    function automatic void model_edge(input bit en, input bit az);
        logic [4:0] o;
        bit taken;
        if (!en || m_halt) return;
        o = m_ir[15:11];
        if (m_valid && o == 5'd0) begin
            m_halt = 1;
            return;
        end
        taken = BR_EN && m_valid && (o == 5'd10 || (o == 5'd8 && az) || (o == 5'd9 && !az));
        m_ir = mem[m_pc];
        m_valid = !taken;
        m_pc = taken ? int'(m_ir_target(o)) : (m_pc + 1) % 2048;
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
    endfunction

    // Branch target must come from the IR before it is overwritten; captured separately.
    logic [10:0] tgt_hold;
    function automatic logic [10:0] m_ir_target(input logic [4:0] o);
        return (o == 5'd0) ? 11'd0 : tgt_hold;
    endfunction

    task automatic tick(input bit en, input bit az);
        enable = en;
        acc_zero = az;
        @(posedge clock);
        tgt_hold = m_ir[10:0];
        model_edge(en, az);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #2;
        model_reset();
        reset = 1'b0;
        #1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 2048; i++) mem[i] = ins(31, 0);
    endtask

    task automatic test_reset();
        fill_nop();
        mem[0] = ins(3, $urandom_range(0, 2047));
        enable = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (pc !== 11'd0 || strobes !== 7'd0 || halted !== 1'b0 || cycle_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_values: pc=%0h strobes=%b halted=%b cnt=%0d want 0/0/0/0",
                     pc, strobes, halted, cycle_count);
        end
        #1;
        model_reset();
        reset = 1'b0;
        tick(1, 0);
        checks++;
        if (pc !== 11'd1 || operand !== mem[0][10:0] || strobes !== 7'b01_0_0_100) begin
            failures++;
            $display("FAIL first_fetch: pc=%0h operand=%0h strobes=%b want 1/%0h/0100100",
                     pc, operand, strobes, mem[0][10:0]);
        end
    endtask

    task automatic load_ldi_prog();
        fill_nop();
        mem[0] = ins(3, 5);
        mem[1] = ins(5, 3);
        mem[2] = ins(1, 2);
        mem[3] = ins(0, 0);
    endtask

    task automatic test_program();
        load_ldi_prog();
        do_reset();
        tick(1, 0);
        checks++;
        if (strobes !== 7'b01_0_0_100 || operand !== 11'd5) begin
            failures++;
            $display("FAIL prog_ldi: strobes=%b operand=%0d want 0100100/5", strobes, operand);
        end
        tick(1, 0);
        checks++;
        if (strobes !== 7'b10_1_0_100 || operand !== 11'd3) begin
            failures++;
            $display("FAIL prog_addi: strobes=%b operand=%0d want 1010100/3", strobes, operand);
        end
        tick(1, 0);
        checks++;
        if (strobes !== 7'b00_0_0_010 || operand !== 11'd2) begin
            failures++;
            $display("FAIL prog_sto: strobes=%b operand=%0d want 0000010/2", strobes, operand);
        end
        tick(1, 0);
        checks++;
        if (strobes !== 7'd0 || halted !== 1'b0 || pc !== 11'd4) begin
            failures++;
            $display("FAIL prog_hlt_cycle: strobes=%b halted=%b pc=%0d want 0/0/4", strobes, halted, pc);
        end
        tick(1, 0);
        tick(1, 0);
        checks++;
        if (halted !== 1'b1 || pc !== 11'd4 || cycle_count !== 32'd4 || strobes !== 7'd0) begin
            failures++;
            $display("FAIL prog_halted: halted=%b pc=%0d cnt=%0d strobes=%b want 1/4/4/0",
                     halted, pc, cycle_count, strobes);
        end
    endtask

    task automatic test_stall();
        load_ldi_prog();
        do_reset();
        tick(1, 0);
        tick(1, 0);
        for (int i = 0; i < 3; i++) begin
            enable = 1'b0;
            #1;
            checks++;
            if (pc !== 11'd2 || operand !== 11'd3 || cycle_count !== 32'd2 || strobes !== 7'd0) begin
                failures++;
                $display("FAIL stall_%0d: pc=%0d operand=%0d cnt=%0d strobes=%b want 2/3/2/0",
                         i, pc, operand, cycle_count, strobes);
            end
            tick(0, 0);
        end
        enable = 1'b1;
        #1;
        checks++;
        if (strobes !== 7'b10_1_0_100 || pc !== 11'd2) begin
            failures++;
            $display("FAIL stall_resume: strobes=%b pc=%0d want 1010100/2", strobes, pc);
        end
        tick(1, 0);
        checks++;
        if (strobes !== 7'b00_0_0_010 || operand !== 11'd2 || cycle_count !== 32'd3) begin
            failures++;
            $display("FAIL stall_sto: strobes=%b operand=%0d cnt=%0d want 0000010/2/3",
                     strobes, operand, cycle_count);
        end
    endtask

    task automatic test_branch();
        fill_nop();
        mem[0] = ins(3, 0);
        mem[2] = ins(8, 7);
        mem[3] = ins(3, 3);
        mem[7] = ins(3, 9);
        do_reset();
        tick(1, 1);
        tick(1, 1);
        tick(1, 1);
        checks++;
        if (strobes !== 7'd0 || pc !== 11'd3) begin
            failures++;
            $display("FAIL beq_decode: strobes=%b pc=%0d want 0/3", strobes, pc);
        end
        tick(1, 1);
        checks++;
        if (BR_EN) begin
            if (pc !== 11'd7 || strobes !== 7'd0) begin
                failures++;
                $display("FAIL beq_taken_bubble: pc=%0d strobes=%b want 7/0", pc, strobes);
            end
        end else if (pc !== 11'd4 || operand !== 11'd3 || strobes !== 7'b01_0_0_100) begin
            failures++;
            $display("FAIL beq_nop: pc=%0d operand=%0d strobes=%b want 4/3/0100100",
                     pc, operand, strobes);
        end
        tick(1, 1);
        checks++;
        if (BR_EN) begin
            if (pc !== 11'd8 || operand !== 11'd9 || strobes !== 7'b01_0_0_100) begin
                failures++;
                $display("FAIL beq_target_exec: pc=%0d operand=%0d strobes=%b want 8/9/0100100",
                         pc, operand, strobes);
            end
        end else if (pc !== 11'd5 || strobes !== 7'd0) begin
            failures++;
            $display("FAIL beq_nop_next: pc=%0d strobes=%b want 5/0", pc, strobes);
        end
        do_reset();
        for (int i = 0; i < 4; i++) tick(1, 0);
        checks++;
        if (pc !== 11'd4 || operand !== 11'd3 || strobes !== 7'b01_0_0_100) begin
            failures++;
            $display("FAIL beq_fallthrough: pc=%0d operand=%0d strobes=%b want 4/3/0100100",
                     pc, operand, strobes);
        end
    endtask

    task automatic test_wrap();
        fill_nop();
        do_reset();
        for (int i = 0; i < 2047; i++) tick(1, 0);
        checks++;
        if (pc !== 11'd2047) begin
            failures++;
            $display("FAIL wrap_top: pc=%0d want 2047", pc);
        end
        tick(1, 0);
        checks++;
        if (pc !== 11'd0 || cycle_count !== 32'd2048) begin
            failures++;
            $display("FAIL wrap_zero: pc=%0d cnt=%0d want 0/2048", pc, cycle_count);
        end
        tick(1, 0);
        checks++;
        if (pc !== 11'd1 || cycle_count !== 32'd2049) begin
            failures++;
            $display("FAIL wrap_after: pc=%0d cnt=%0d want 1/2049", pc, cycle_count);
        end
    endtask

    task automatic test_async_reset();
        load_ldi_prog();
        do_reset();
        for (int i = 0; i < 6; i++) tick(1, 0);
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_reached: halted=%b want 1", halted);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0 || pc !== 11'd0 || cycle_count !== 32'd0 || operand !== 11'd0) begin
            failures++;
            $display("FAIL reset_in_halt: halted=%b pc=%0d cnt=%0d operand=%0d want 0/0/0/0",
                     halted, pc, cycle_count, operand);
        end
        reset = 1'b0;
        model_reset();
        fill_nop();
        mem[0] = ins(4, 6);
        do_reset();
        tick(1, 0);
        checks++;
        if (strobes !== 7'b10_0_0_101) begin
            failures++;
            $display("FAIL add_exec: strobes=%b want 1000101", strobes);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (strobes !== 7'd0 || pc !== 11'd0 || operand !== 11'd0 || cycle_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_add: strobes=%b pc=%0d operand=%0d cnt=%0d want 0/0/0/0",
                     strobes, pc, operand, cycle_count);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        bit en, az;
        logic [6:0] exp_s;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 2048; i++) begin
                mem[i] = ins(($urandom_range(0, 63) == 0) ? 0 : $urandom_range(1, 31),
                             $urandom_range(0, 2047));
            end
            do_reset();
            for (int c = 0; c < 300; c++) begin
                en = ($urandom_range(0, 3) != 0);
                az = $urandom_range(0, 1);
                enable = en;
                acc_zero = az;
                #1;
                exp_s = (en && m_valid && !m_halt) ? exp_dec(m_ir[15:11]) : 7'd0;
                checks++;
                if (pc !== m_pc[10:0] || operand !== m_ir[10:0] || strobes !== exp_s ||
                    halted !== m_halt || cycle_count !== m_cnt[31:0]) begin
                    failures++;
                    $display("FAIL random r%0d c%0d: pc=%0h/%0h opd=%0h/%0h str=%b/%b hlt=%b/%b cnt=%0d/%0d",
                             r, c, pc, m_pc[10:0], operand, m_ir[10:0], strobes, exp_s,
                             halted, m_halt, cycle_count, m_cnt[31:0]);
                end
                tick(en, az);
            end
        end
    endtask

    initial begin
        model_reset();
        fill_nop();
        test_reset();
        test_program();
        test_stall();
        test_branch();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
